// File: rtl/lc3_control_fsm_if.sv
// lc3_control_fsm_if: control bundle between the LC-3 sequencer and the
// rest of the CPU (IR fields, Run/Continue, datapath loads/gates/selects and
// the active-low SRAM strobes).
//
// There is no valid/ready handshake on this bundle. Every signal is a level
// that holds for a whole clock cycle. Inputs are sampled on the rising edge
// of Clk. Outputs change only after a rising edge (or on Reset) and stay
// stable until the next one.
interface lc3_control_fsm_if;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       BEN;

    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
    logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

    // Sequencer side.
    modport master (
        input  Run, Continue, Opcode, IR_5, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, ADDR2MUX, ALUK,
        output DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
        output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
    );

    // CPU wrapper / datapath / memory side.
    modport slave (
        output Run, Continue, Opcode, IR_5, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, ADDR2MUX, ALUK,
        input  DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
        input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
    );
endinterface

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: Moore sequencer for the LC-3 subset CPU. Walks fetch,
// decode and execute and drives every load, gate, mux select and SRAM strobe
// from the current state.
//
// Optional feature macro: PAUSE_INSTR_EN. When defined, opcode 1101 parks
// the machine in a pause loop (LED latch loaded) until Continue is pressed
// and released. When undefined, 1101 behaves as a NOP and Continue is unused.
//
// state_dbg exposes the current state encoding for debug and checkers.
module lc3_control_fsm (
    input  logic               Clk,
    input  logic               Reset,
    lc3_control_fsm_if.master  bus,
    output logic [4:0]         state_dbg
);

    typedef enum logic [4:0] {
        HALTED,
        S18, S33_1, S33_2, S35, S32,
        S01, S05, S09,
        S00, S22,
        S12,
        S04, S21,
        S06, S25_1, S25_2, S27,
        S07, S23, S16_1, S16_2,
        PAUSE_IR1, PAUSE_IR2
    } state_t;

    state_t state;
    state_t next_state;

    assign state_dbg = state;

    // State register; Reset drops straight back to Halted.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= HALTED;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        next_state     = state;

        bus.LD_MAR     = 1'b0;
        bus.LD_MDR     = 1'b0;
        bus.LD_IR      = 1'b0;
        bus.LD_BEN     = 1'b0;
        bus.LD_CC      = 1'b0;
        bus.LD_REG     = 1'b0;
        bus.LD_PC      = 1'b0;
        bus.LD_LED     = 1'b0;
        bus.GatePC     = 1'b0;
        bus.GateMDR    = 1'b0;
        bus.GateALU    = 1'b0;
        bus.GateMARMUX = 1'b0;
        bus.PCMUX      = 2'b00;
        bus.ADDR2MUX   = 2'b00;
        bus.ALUK       = 2'b00;
        bus.DRMUX      = 1'b0;
        bus.SR1MUX     = 1'b0;
        bus.SR2MUX     = 1'b0;
        bus.ADDR1MUX   = 1'b0;
        bus.MIO_EN     = 1'b0;
        bus.Mem_CE     = 1'b1;
        bus.Mem_UB     = 1'b1;
        bus.Mem_LB     = 1'b1;
        bus.Mem_OE     = 1'b1;
        bus.Mem_WE     = 1'b1;

        unique case (state)
            HALTED: begin
                if (bus.Run) next_state = S18;
            end

            // ---- fetch ----
            S18: begin
                bus.GatePC = 1'b1;
                bus.LD_MAR = 1'b1;
                bus.LD_PC  = 1'b1;
                bus.PCMUX  = 2'b00;
                next_state = S33_1;
            end
            S33_1: begin
                bus.MIO_EN = 1'b1;
                bus.Mem_CE = 1'b0;
                bus.Mem_UB = 1'b0;
                bus.Mem_LB = 1'b0;
                bus.Mem_OE = 1'b0;
                next_state = S33_2;
            end
            S33_2: begin
                bus.MIO_EN = 1'b1;
                bus.LD_MDR = 1'b1;
                bus.Mem_CE = 1'b0;
                bus.Mem_UB = 1'b0;
                bus.Mem_LB = 1'b0;
                bus.Mem_OE = 1'b0;
                next_state = S35;
            end
            S35: begin
                bus.GateMDR = 1'b1;
                bus.LD_IR   = 1'b1;
                next_state  = S32;
            end
            S32: begin
                bus.LD_BEN = 1'b1;
                case (bus.Opcode)
                    4'b0001: next_state = S01;
                    4'b0101: next_state = S05;
                    4'b1001: next_state = S09;
                    4'b0000: next_state = S00;
                    4'b1100: next_state = S12;
                    4'b0100: next_state = S04;
                    4'b0110: next_state = S06;
                    4'b0111: next_state = S07;
`ifdef PAUSE_INSTR_EN
                    4'b1101: next_state = PAUSE_IR1;
`endif
                    default: next_state = S18;
                endcase
            end

            // ---- ALU operate ----
            S01, S05: begin
                bus.SR1MUX  = 1'b1;
                bus.SR2MUX  = bus.IR_5;
                bus.ALUK    = (state == S05) ? 2'b01 : 2'b00;
                bus.GateALU = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                next_state  = S18;
            end
            S09: begin
                bus.SR1MUX  = 1'b1;
                bus.ALUK    = 2'b10;
                bus.GateALU = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                next_state  = S18;
            end

            // ---- branch; BEN was loaded at the S32 edge ----
            S00: begin
                next_state = bus.BEN ? S22 : S18;
            end
            S22: begin
                bus.ADDR1MUX = 1'b0;
                bus.ADDR2MUX = 2'b10;
                bus.PCMUX    = 2'b10;
                bus.LD_PC    = 1'b1;
                next_state   = S18;
            end

            // ---- jump through base register ----
            S12: begin
                bus.SR1MUX  = 1'b1;
                bus.ALUK    = 2'b11;
                bus.GateALU = 1'b1;
                bus.PCMUX   = 2'b01;
                bus.LD_PC   = 1'b1;
                next_state  = S18;
            end

            // ---- subroutine call: save PC in R7, then PC-relative jump ----
            S04: begin
                bus.GatePC = 1'b1;
                bus.DRMUX  = 1'b1;
                bus.LD_REG = 1'b1;
                next_state = S21;
            end
            S21: begin
                bus.ADDR1MUX = 1'b0;
                bus.ADDR2MUX = 2'b11;
                bus.PCMUX    = 2'b10;
                bus.LD_PC    = 1'b1;
                next_state   = S18;
            end

            // ---- base+offset address into MAR (LDR and STR share this) ----
            S06, S07: begin
                bus.ADDR1MUX   = 1'b1;
                bus.SR1MUX     = 1'b1;
                bus.ADDR2MUX   = 2'b01;
                bus.GateMARMUX = 1'b1;
                bus.LD_MAR     = 1'b1;
                next_state     = (state == S06) ? S25_1 : S23;
            end
            S25_1: begin
                bus.MIO_EN = 1'b1;
                bus.Mem_CE = 1'b0;
                bus.Mem_UB = 1'b0;
                bus.Mem_LB = 1'b0;
                bus.Mem_OE = 1'b0;
                next_state = S25_2;
            end
            S25_2: begin
                bus.MIO_EN = 1'b1;
                bus.LD_MDR = 1'b1;
                bus.Mem_CE = 1'b0;
                bus.Mem_UB = 1'b0;
                bus.Mem_LB = 1'b0;
                bus.Mem_OE = 1'b0;
                next_state = S27;
            end
            S27: begin
                bus.GateMDR = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                next_state  = S18;
            end

            // ---- store: source register (IR[11:9]) into MDR, then write ----
            S23: begin
                bus.SR1MUX  = 1'b0;
                bus.ALUK    = 2'b11;
                bus.GateALU = 1'b1;
                bus.LD_MDR  = 1'b1;
                bus.MIO_EN  = 1'b0;
                next_state  = S16_1;
            end
            S16_1: begin
                bus.Mem_CE = 1'b0;
                bus.Mem_UB = 1'b0;
                bus.Mem_LB = 1'b0;
                bus.Mem_WE = 1'b0;
                next_state = S16_2;
            end
            S16_2: begin
                bus.Mem_CE = 1'b0;
                bus.Mem_UB = 1'b0;
                bus.Mem_LB = 1'b0;
                bus.Mem_WE = 1'b0;
                next_state = S18;
            end

`ifdef PAUSE_INSTR_EN
            // ---- pause: wait for a full press-and-release of Continue ----
            PAUSE_IR1: begin
                bus.LD_LED = 1'b1;
                if (bus.Continue) next_state = PAUSE_IR2;
            end
            PAUSE_IR2: begin
                if (!bus.Continue) next_state = S18;
            end
`endif

            default: begin
                next_state = HALTED;
            end
        endcase
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: directed bench for the LC-3 control sequencer. A
// reference model expands each instruction into its per-cycle list of
// control bundles; a compare process checks the DUT against that list every
// cycle, and a few literal spot checks pin the model itself.
module tb_lc3_control_fsm;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       drmux, sr1mux, sr2mux, addr1mux, mio_en;
        logic       mem_ce, mem_ub, mem_lb, mem_oe, mem_we;
    } ctl_t;

    localparam int W = $bits(ctl_t);

    // ---------------- clock / reset ----------------
    logic       Clk = 1'b0;
    logic       Reset;
    logic [4:0] state_dbg;

    always #5 Clk = ~Clk;

    lc3_control_fsm_if bus ();

    lc3_control_fsm dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    int           assertions = 0;
    int           failures   = 0;
    int           cyc        = 0;

    function automatic ctl_t sample();
        ctl_t s;
        s.ld_mar      = bus.LD_MAR;
        s.ld_mdr      = bus.LD_MDR;
        s.ld_ir       = bus.LD_IR;
        s.ld_ben      = bus.LD_BEN;
        s.ld_cc       = bus.LD_CC;
        s.ld_reg      = bus.LD_REG;
        s.ld_pc       = bus.LD_PC;
        s.ld_led      = bus.LD_LED;
        s.gate_pc     = bus.GatePC;
        s.gate_mdr    = bus.GateMDR;
        s.gate_alu    = bus.GateALU;
        s.gate_marmux = bus.GateMARMUX;
        s.pcmux       = bus.PCMUX;
        s.addr2mux    = bus.ADDR2MUX;
        s.aluk        = bus.ALUK;
        s.drmux       = bus.DRMUX;
        s.sr1mux      = bus.SR1MUX;
        s.sr2mux      = bus.SR2MUX;
        s.addr1mux    = bus.ADDR1MUX;
        s.mio_en      = bus.MIO_EN;
        s.mem_ce      = bus.Mem_CE;
        s.mem_ub      = bus.Mem_UB;
        s.mem_lb      = bus.Mem_LB;
        s.mem_oe      = bus.Mem_OE;
        s.mem_we      = bus.Mem_WE;
        return s;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One check per cycle whenever the model has an expectation queued.
    always @(negedge Clk) begin
        cyc++;
        if (!Reset && exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            chk($sformatf("ctl_cycle%0d", cyc), W'(sample()), exp_v);
        end
    end

    // ---------------- reference model ----------------
    function automatic ctl_t idle();
        ctl_t c;
        c        = '0;
        c.mem_ce = 1'b1;
        c.mem_ub = 1'b1;
        c.mem_lb = 1'b1;
        c.mem_oe = 1'b1;
        c.mem_we = 1'b1;
        return c;
    endfunction

    function automatic ctl_t mem_read(input logic capture);
        ctl_t c;
        c        = idle();
        c.mem_ce = 1'b0;
        c.mem_ub = 1'b0;
        c.mem_lb = 1'b0;
        c.mem_oe = 1'b0;
        c.mio_en = 1'b1;
        c.ld_mdr = capture;
        return c;
    endfunction

    function automatic ctl_t mem_write();
        ctl_t c;
        c        = idle();
        c.mem_ce = 1'b0;
        c.mem_ub = 1'b0;
        c.mem_lb = 1'b0;
        c.mem_we = 1'b0;
        return c;
    endfunction

    function automatic ctl_t base_offset_to_mar();
        ctl_t c;
        c             = idle();
        c.addr1mux    = 1'b1;
        c.sr1mux      = 1'b1;
        c.addr2mux    = 2'b01;
        c.gate_marmux = 1'b1;
        c.ld_mar      = 1'b1;
        return c;
    endfunction

    // Expected bundle sequence for one instruction, starting at fetch.
    // Only the first lim entries are queued.
    task automatic push_instr(input logic [3:0] op, input logic ir5, input logic ben, input int lim);
        ctl_t seq[$];
        ctl_t c;
        c = idle(); c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; seq.push_back(c);
        seq.push_back(mem_read(1'b0));
        seq.push_back(mem_read(1'b1));
        c = idle(); c.gate_mdr = 1; c.ld_ir = 1; seq.push_back(c);
        c = idle(); c.ld_ben = 1; seq.push_back(c);
        case (op)
            4'b0001, 4'b0101: begin
                c = idle(); c.sr1mux = 1; c.sr2mux = ir5;
                c.aluk = (op == 4'b0001) ? 2'd0 : 2'd1;
                c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; seq.push_back(c);
            end
            4'b1001: begin
                c = idle(); c.sr1mux = 1; c.aluk = 2'd2;
                c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; seq.push_back(c);
            end
            4'b0000: begin
                seq.push_back(idle());
                if (ben) begin
                    c = idle(); c.addr2mux = 2'd2; c.pcmux = 2'd2; c.ld_pc = 1; seq.push_back(c);
                end
            end
            4'b1100: begin
                c = idle(); c.sr1mux = 1; c.aluk = 2'd3; c.gate_alu = 1;
                c.pcmux = 2'd1; c.ld_pc = 1; seq.push_back(c);
            end
            4'b0100: begin
                c = idle(); c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; seq.push_back(c);
                c = idle(); c.addr2mux = 2'd3; c.pcmux = 2'd2; c.ld_pc = 1; seq.push_back(c);
            end
            4'b0110: begin
                seq.push_back(base_offset_to_mar());
                seq.push_back(mem_read(1'b0));
                seq.push_back(mem_read(1'b1));
                c = idle(); c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; seq.push_back(c);
            end
            4'b0111: begin
                seq.push_back(base_offset_to_mar());
                c = idle(); c.aluk = 2'd3; c.gate_alu = 1; c.ld_mdr = 1; seq.push_back(c);
                seq.push_back(mem_write());
                seq.push_back(mem_write());
            end
            default: ;
        endcase
        for (int i = 0; i < seq.size() && i < lim; i++) exp_q.push_back(W'(seq[i]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            @(negedge Clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            assertions++;
            failures++;
            $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Call at #1 into an S18 cycle; returns at #1 into the following S18.
    task automatic run_instr(input logic [3:0] op, input logic ir5, input logic ben);
        bus.Opcode = op;
        bus.IR_5   = ir5;
        bus.BEN    = ben;
        push_instr(op, ir5, ben, 100);
        wait_drain();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_run();
        @(posedge Clk);
        #1 bus.Run = 1'b1;
        @(posedge Clk);
        #1 bus.Run = 1'b0;
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        chk(name, W'(act), W'(exp));
    endtask

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        chk(name, W'(act), W'(exp));
    endtask

    task automatic idle_cycles(input int n);
        @(posedge Clk);
        #1;
        for (int i = 0; i < n; i++) exp_q.push_back(W'(idle()));
        wait_drain();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.Run      = 1'b0;
        bus.Continue = 1'b0;
        bus.Opcode   = 4'h0;
        bus.IR_5     = 1'b0;
        bus.BEN      = 1'b0;
        Reset        = 1'b1;

        #1;
        chk("reset_defaults", W'(sample()), W'(idle()));
        chk_bit("reset_mem_ce", bus.Mem_CE, 1'b1);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // Halted with Run low: nothing moves.
        idle_cycles(4);

        // Run pulse: the next cycle is S18.
        start_run();
        chk_bit("s18_gatepc", bus.GatePC, 1'b1);
        chk_bit("s18_ld_mar", bus.LD_MAR, 1'b1);
        chk_bit("s18_ld_pc",  bus.LD_PC,  1'b1);
        chk2("s18_pcmux", bus.PCMUX, 2'b00);

        // ADD immediate with spot checks: LD_BEN 4 cycles after S18.
        bus.Opcode = 4'b0001; bus.IR_5 = 1'b1; bus.BEN = 1'b0;
        push_instr(4'b0001, 1'b1, 1'b0, 100);
        repeat (4) @(posedge Clk);
        #1 chk_bit("fetch_ld_ben_at_4", bus.LD_BEN, 1'b1);
        @(posedge Clk);
        #1 chk_bit("add_sr2mux_imm", bus.SR2MUX, 1'b1);
        chk_bit("add_gatealu", bus.GateALU, 1'b1);
        wait_drain();
        @(posedge Clk);
        #1 chk_bit("add_back_to_s18", bus.GatePC, 1'b1);

        run_instr(4'b0001, 1'b0, 1'b0);   // ADD register
        run_instr(4'b0101, 1'b1, 1'b0);   // AND immediate
        run_instr(4'b0101, 1'b0, 1'b1);   // AND register
        run_instr(4'b1001, 1'b0, 1'b0);   // NOT
        run_instr(4'b0000, 1'b0, 1'b0);   // BR not taken

        // BR taken with a spot check on S22.
        bus.Opcode = 4'b0000; bus.BEN = 1'b1;
        push_instr(4'b0000, 1'b0, 1'b1, 100);
        repeat (6) @(posedge Clk);
        #1 chk2("br_taken_pcmux", bus.PCMUX, 2'b10);
        chk2("br_taken_addr2mux", bus.ADDR2MUX, 2'b10);
        wait_drain();
        @(posedge Clk);
        #1;

        run_instr(4'b1100, 1'b0, 1'b0);   // JMP
        run_instr(4'b0100, 1'b0, 1'b0);   // JSR
        run_instr(4'b0110, 1'b0, 1'b0);   // LDR

        // STR with spot checks on S23 and the write cycle.
        bus.Opcode = 4'b0111; bus.BEN = 1'b0;
        push_instr(4'b0111, 1'b0, 1'b0, 100);
        repeat (6) @(posedge Clk);
        #1 chk_bit("str_s23_ld_mdr", bus.LD_MDR, 1'b1);
        chk_bit("str_s23_mio_en", bus.MIO_EN, 1'b0);
        @(posedge Clk);
        #1 chk_bit("str_write_we", bus.Mem_WE, 1'b0);
        chk_bit("str_write_oe", bus.Mem_OE, 1'b1);
        wait_drain();
        @(posedge Clk);
        #1;

        run_instr(4'b0011, 1'b0, 1'b0);   // unused opcode -> NOP
        run_instr(4'b1111, 1'b1, 1'b1);   // unused opcode -> NOP

`ifdef PAUSE_INSTR_EN
        // Pause: 3 cycles in PauseIR1, press at cycle 7, release at cycle 11.
        begin
            ctl_t c;
            bus.Opcode = 4'b1101; bus.Continue = 1'b0;
            push_instr(4'b1101, 1'b0, 1'b0, 5);
            c = idle(); c.ld_led = 1'b1;
            for (int i = 0; i < 3; i++) exp_q.push_back(W'(c));
            for (int i = 0; i < 4; i++) exp_q.push_back(W'(idle()));
            repeat (6) @(posedge Clk);
            #1 chk_bit("pause_ld_led", bus.LD_LED, 1'b1);
            @(posedge Clk);
            #1 bus.Continue = 1'b1;
            repeat (4) @(posedge Clk);
            #1 bus.Continue = 1'b0;
            wait_drain();
            @(posedge Clk);
            #1 chk_bit("pause_resume_s18", bus.GatePC, 1'b1);
        end
`else
        // Without the pause feature 1101 is a plain NOP.
        bus.Opcode = 4'b1101; bus.Continue = 1'b1;
        push_instr(4'b1101, 1'b0, 1'b0, 100);
        wait_drain();
        @(posedge Clk);
        #1 chk_bit("op1101_nop_s18", bus.GatePC, 1'b1);
        chk_bit("op1101_no_led", bus.LD_LED, 1'b0);
        bus.Continue = 1'b0;
`endif

        // Reset in the middle of S25_1 of an LDR.
        bus.Opcode = 4'b0110;
        push_instr(4'b0110, 1'b0, 1'b0, 7);
        repeat (6) @(posedge Clk);
        #7 Reset = 1'b1;
        #1 chk("reset_mid_s25", W'(sample()), W'(idle()));
        chk_bit("reset_mid_oe", bus.Mem_OE, 1'b1);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        exp_q.delete();
        idle_cycles(5);

        // Restart after reset.
        start_run();
        chk_bit("restart_s18", bus.GatePC, 1'b1);
        run_instr(4'b0001, 1'b1, 1'b0);
        run_instr(4'b0111, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
